// File: rtl/mem_responder.sv
// Memory-side responder: single outstanding request, programmable wait states,
// byte-masked writes into an internal word store, registered valid/ready response.
module mem_responder #(
  parameter int ADDR_W  = 13,
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_req_we,
  input  logic [31:0]       i_req_wdata,
  input  logic [3:0]        i_req_wstrb,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_busy
);

  // state   | meaning
  // IDLE    | ready for a new request
  // WAIT    | burning LATENCY wait states
  // ACCESS  | one memory read or write on the captured request
  // RESP    | response held until the requester takes it
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int                IDX_W   = $clog2(DEPTH);
  localparam logic [3:0]        LAT_L   = 4'(LATENCY);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              ready_en;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [31:0]       req_wdata;
  logic [3:0]        req_wstrb;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       mem [DEPTH];

  // ready_en keeps o_req_ready low through the reset cycle itself
  assign o_req_ready = (state == ST_IDLE) && ready_en;
  assign o_busy      = (state != ST_IDLE);
  assign in_range    = ({1'b0, req_addr} < DEPTH_L);
  assign idx         = req_addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= 4'd0;
      ready_en    <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= 32'd0;
      o_rsp_err   <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (i_req_valid && o_req_ready) begin
            req_addr  <= i_req_addr;
            req_we    <= i_req_we;
            req_wdata <= i_req_wdata;
            req_wstrb <= i_req_wstrb;
            wait_cnt  <= LAT_L;
            state     <= (LAT_L != 4'd0) ? ST_WAIT : ST_ACCESS;
          end
        end
        ST_WAIT: begin
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          o_rsp_valid <= 1'b1;
          o_rsp_err   <= !in_range;
          o_rsp_rdata <= (in_range && !req_we) ? mem[idx] : 32'd0;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= 32'd0;
            o_rsp_err   <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // storage is never reset; a write only lands from ACCESS outside reset
  always_ff @(posedge clk) begin
    if (reset && state == ST_ACCESS && in_range && req_we) begin
      for (int k = 0; k < 4; k++) begin
        if (req_wstrb[k]) mem[idx][8*k +: 8] <= req_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table at LATENCY=2 plus hand sequences
// for reset, backpressure, mid-operation reset and LATENCY=0 back-to-back traffic.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, busy;
  logic [12:0] req_addr;
  logic [31:0] req_wdata, rsp_rdata;
  logic [3:0]  req_wstrb;

  logic        v0, rdy0, we0, rv0, rr0, err0, busy0;
  logic [12:0] addr0;
  logic [31:0] wdata0, rdata0;
  logic [3:0]  wstrb0;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int acc_q[$];
  int rsp_q[$];
  logic [31:0] rd_q[$];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(13), .DEPTH(4096), .LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .i_req_we(req_we), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_rsp_err(rsp_err), .o_busy(busy)
  );

  mem_responder #(.ADDR_W(13), .DEPTH(4096), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .i_req_valid(v0), .o_req_ready(rdy0), .i_req_addr(addr0),
    .i_req_we(we0), .i_req_wdata(wdata0), .i_req_wstrb(wstrb0),
    .o_rsp_valid(rv0), .i_rsp_ready(rr0), .o_rsp_rdata(rdata0),
    .o_rsp_err(err0), .o_busy(busy0)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset && v0 && rdy0) acc_q.push_back(cyc);
    if (reset && rv0 && rr0) begin
      rsp_q.push_back(cyc);
      rd_q.push_back(rdata0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic do_txn(input logic we, input logic [12:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int hold,
                        output logic [31:0] rdata, output logic err);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 13'h1FFF; req_wdata = 32'h0BAD0BAD; req_wstrb = 4'hF;
    chk("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    // valid registered after edge N+L+1, i.e. sampled by the requester at N+L+2
    chk("latency_edges", 32'(n), 32'd3);
    rdata = rsp_rdata;
    err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, rdata);
      chk("bp_err", 32'(rsp_err), 32'(err));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_valid", 32'(rsp_valid), 32'd0);
    chk("post_hs_rdata", rsp_rdata, 32'd0);
    chk("post_hs_ready", 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          n;

    vecs[0]  = '{1'b1, 13'h0010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 13'h0010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 13'h0020, 32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 13'h0020, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 13'h0020, 32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b1, 13'h0000, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[6]  = '{1'b1, 13'h1000, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 13'h0000, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    vecs[8]  = '{1'b0, 13'h1000, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[9]  = '{1'b1, 13'h0010, 32'h12345678, 4'h0, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 13'h0010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[11] = '{1'b1, 13'h0FFF, 32'h0A0B0C0D, 4'hF, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 13'h0FFF, 32'h0,        4'h0, 32'h0A0B0C0D, 1'b0};

    reset = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 13'h10;
    req_wdata = 32'h0; req_wstrb = 4'hF; rsp_ready = 1'b1;
    v0 = 1'b0; we0 = 1'b0; addr0 = 13'h0; wdata0 = 32'h0; wstrb0 = 4'h0; rr0 = 1'b1;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    @(negedge clk); reset = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_release", 32'(req_ready), 32'd1);
    chk("busy_after_release", 32'(busy), 32'd0);

    for (int i = 0; i < 13; i++) begin
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, 0, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    do_txn(1'b0, 13'h0010, 32'h0, 4'h0, 5, rd, er);
    chk("bp_read_rdata", rd, 32'hDEADBEEF);
    chk("bp_read_err", 32'(er), 32'd0);

    // reset while the write sits in WAIT: it must never reach memory
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 13'h0020; req_wdata = 32'h99999999; req_wstrb = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("midrst_busy_wait", 32'(busy), 32'd1);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    do_txn(1'b0, 13'h0020, 32'h0, 4'h0, 0, rd, er);
    chk("midrst_old_data", rd, 32'h11BB33DD);

    // LATENCY=0 instance, i_rsp_ready tied high, valid held high
    acc_q.delete(); rsp_q.delete(); rd_q.delete();
    @(negedge clk);
    v0 = 1'b1; we0 = 1'b1; addr0 = 13'h0005; wdata0 = 32'h55AA55AA; wstrb0 = 4'hF;
    n = 0;
    while (acc_q.size() < 1 && n < 20) begin @(posedge clk); #1; n++; end
    we0 = 1'b0;
    while (acc_q.size() < 4 && n < 60) begin @(posedge clk); #1; n++; end
    @(negedge clk); v0 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("l0_accept_count", 32'(acc_q.size()), 32'd4);
    chk("l0_rsp_count", 32'(rsp_q.size()), 32'd4);
    for (int i = 1; i < acc_q.size() && i < 4; i++)
      chk($sformatf("l0_spacing%0d", i), 32'(acc_q[i] - acc_q[i-1]), 32'd3);
    for (int i = 0; i < rsp_q.size() && i < acc_q.size() && i < 4; i++) begin
      chk($sformatf("l0_rsp_edge%0d", i), 32'(rsp_q[i] - acc_q[i]), 32'd2);
      chk($sformatf("l0_rdata%0d", i), rd_q[i], (i == 0) ? 32'h0 : 32'h55AA55AA);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the single-cycle core's unified memory path. It accepts one request at a time over a valid/ready channel from the instruction/data arbiter and performs the read or byte-masked write against an internal 32-bit word store. It inserts a programmable number of wait states and returns a registered response over a second valid/ready channel. It replaces the zero-latency combinational RAM, so the core and arbiter side can be exercised against realistic memory latency and backpressure.

## Interface
- ADDR_W, 13, word-address width; matches the arbiter's address bus.
- DEPTH, 4096, number of implemented 32-bit words. Addresses at or above DEPTH are out of range.
- LATENCY, 2, wait states inserted between request acceptance and memory access. Legal range 0..15.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- i_req_valid  input  1  request present.
- o_req_ready  output  1  responder can accept a request this cycle.
- i_req_addr  input  ADDR_W  word address.
- i_req_we  input  1  1 = write, 0 = read.
- i_req_wdata  input  32  write data.
- i_req_wstrb  input  4  byte enables; bit k enables byte [8k+7:8k]. Ignored for reads.
- o_rsp_valid  output  1  response present.
- i_rsp_ready  input  1  requester accepts the response.
- o_rsp_rdata  output  32  read data. 0 for writes and for errors.
- o_rsp_err  output  1  request was out of range.
- o_busy  output  1  high in every state except IDLE.

## Operation
- **States:** IDLE, WAIT, ACCESS, RESP.
- **IDLE:**
  - o_req_ready = 1.
  - On i_req_valid & o_req_ready, capture addr, we, wdata and wstrb into the request registers, and load the wait counter with LATENCY.
  - Next state is WAIT if LATENCY > 0, otherwise ACCESS.
- **WAIT:**
  - o_req_ready = 0.
  - Decrement the counter each cycle. When the counter reaches 1, the next state is ACCESS.
- **ACCESS:** performs exactly one memory operation on the captured request.
  - **In range, write:** for each set strobe bit, write the corresponding byte. Response rdata = 0, err = 0.
  - **In range, read:** register mem[addr] into o_rsp_rdata, err = 0.
  - **Out of range:** no memory modification, rdata = 0, err = 1.
  - Next state is RESP.
- **RESP:**
  - o_rsp_valid = 1. o_rsp_rdata and o_rsp_err are held stable.
  - On i_rsp_ready, go to IDLE, deassert o_rsp_valid, and clear o_rsp_rdata and o_rsp_err to 0.
- **One outstanding request:** no new request is accepted until the response handshake completes. o_req_ready is combinational from the state register only, never from i_req_valid.
- **wstrb = 4'b0000 write:** legal. No bytes change; a normal response is returned.
- **Write then read:** a read following a write to the same address returns the written data. Ordering is guaranteed by the single-outstanding rule.
- **Memory contents:** not reset and undefined until written. Simulation may preload from a hex file.

## Timing
- **Reset (reset = 0 at a rising edge):**
  - state = IDLE, counter = 0.
  - o_req_ready = 0 during the reset cycle, 1 from the first cycle after reset deasserts.
  - o_rsp_valid = 0, o_rsp_rdata = 0, o_rsp_err = 0, o_busy = 0.
- **Reset mid-operation:** the pending request is abandoned, no response is issued, and any write not yet in ACCESS never occurs. A write already performed in ACCESS stays in memory.
- **Latency:** a request accepted at edge N produces o_rsp_valid high from edge N+2+LATENCY. With LATENCY = 0, that is edge N+2.
- **Throughput:** minimum request-to-request spacing is LATENCY+3 cycles when i_rsp_ready is held high.
- **Backpressure:** RESP may last any number of cycles. Response outputs must not change while o_rsp_valid & !i_rsp_ready.
- **Handshake rules:**
  - Requesters may drop i_req_valid before acceptance without effect.
  - Request inputs are sampled only on the accepting edge.
- **Counter:** 4 bits, never underflows, and is don't-care outside WAIT.

## Test plan
- **Reset:** hold reset = 0 for 3 cycles while driving i_req_valid = 1 -> no acceptance. All outputs match their reset values. o_req_ready rises on the first cycle after release.
- **Write then read, LATENCY = 2:**
  - Write addr 0x010, wdata 0xDEADBEEF, wstrb 4'hF -> o_rsp_valid on edge N+4, rdata 0, err 0.
  - Read addr 0x010 -> rdata 0xDEADBEEF.
- **Partial write:**
  - Write 0x11223344 to 0x020 with wstrb 4'hF.
  - Then write 0xAABBCCDD with wstrb 4'b0101.
  - Read 0x020 -> 0x11BB33DD.
- **Out-of-range access, DEPTH = 4096:**
  - Write 0xFFFFFFFF to addr 0x1000 -> err 1, rdata 0.
  - Read addr 0x000 -> unchanged value.
  - Read 0x1000 -> err 1, rdata 0.
- **Backpressure:** hold i_rsp_ready = 0 for 5 cycles during a read of 0x010 -> o_rsp_valid, rdata 0xDEADBEEF and err stay constant, and o_req_ready stays 0 throughout. On i_rsp_ready = 1, return to IDLE on the next edge.
- **LATENCY = 0, back-to-back with reset:**
  - With i_rsp_ready tied 1, issue back-to-back reads -> responses at N+2 and acceptances spaced 3 cycles apart.
  - Assert reset while in WAIT on a write (LATENCY = 2) -> no response, and a subsequent read of that address shows the old data.
